// File: rtl/nec_prefetch.sv
// rtl/nec_prefetch.sv - 8-byte instruction prefetch queue and code-fetch controller
// Optional NEC_PREFETCH_8BIT_EN: 8-bit bus, every fetch is a single byte.
module nec_prefetch #(
    parameter int QUEUE_SIZE = 8,
    parameter int MIN_FREE   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce_1,
    input  logic            ce_2,
    input  logic            flush,
    input  logic [15:0]     flush_ps,
    input  logic [15:0]     flush_pc,
    input  logic [3:0]      consume,
    output logic [3:0]      ipq_len,
    output logic [7:0][7:0] ipq,
    output logic            bus_req,
    output logic [19:0]     bus_addr,
    output logic            bus_word,
    input  logic            bus_ack,
    input  logic [15:0]     bus_data
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam logic [3:0] QSIZE = 4'(QUEUE_SIZE);
`ifndef NEC_PREFETCH_8BIT_EN
    localparam logic [3:0] MINF  = 4'(MIN_FREE);
`endif

    state_t          state, state_nxt;
    logic [15:0]     head_pc, head_nxt;
    logic [15:0]     fetch_pc, fetch_nxt;
    logic [15:0]     ps, ps_nxt;
    logic            discard, discard_nxt;
    logic            req_nxt, word_nxt;
    logic [19:0]     addr_nxt;
    logic [7:0][7:0] ipq_nxt;

    logic            ce;
    logic [3:0]      free;
    logic [19:0]     phys_addr;
    logic            fetch_ok;
    logic            fetch_word;

    assign ce        = ce_1 | ce_2;
    // Queue length is the PC distance; only the low nibble matters since it never exceeds 8.
    assign ipq_len   = fetch_pc[3:0] - head_pc[3:0];
    assign free      = QSIZE - ipq_len;
    assign phys_addr = {ps, 4'h0} + {4'h0, fetch_pc};

    always_comb begin
        fetch_word = 1'b0;
        fetch_ok   = 1'b0;
`ifdef NEC_PREFETCH_8BIT_EN
        fetch_ok = (free >= 4'd1);
`else
        if (fetch_pc[0]) begin
            fetch_ok = (free >= 4'd1);
        end else begin
            fetch_word = 1'b1;
            fetch_ok   = (free >= MINF) && (free >= 4'd2);
        end
`endif
    end

    always_comb begin
        state_nxt   = state;
        head_nxt    = head_pc;
        fetch_nxt   = fetch_pc;
        ps_nxt      = ps;
        discard_nxt = discard;
        req_nxt     = bus_req;
        addr_nxt    = bus_addr;
        word_nxt    = bus_word;
        ipq_nxt     = ipq;

        case (state)
            S_IDLE: begin
                // A flush edge never issues: the fetch would use the stale address.
                if (!flush && fetch_ok) begin
                    state_nxt = S_REQ;
                    req_nxt   = 1'b1;
                    addr_nxt  = phys_addr;
                    word_nxt  = fetch_word;
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    state_nxt   = S_IDLE;
                    req_nxt     = 1'b0;
                    discard_nxt = 1'b0;
                    if (!discard && !flush) begin
`ifdef NEC_PREFETCH_8BIT_EN
                        ipq_nxt[fetch_pc[2:0]] = bus_data[7:0];
                        fetch_nxt = fetch_pc + 16'd1;
`else
                        if (bus_word) begin
                            ipq_nxt[fetch_pc[2:0]]        = bus_data[7:0];
                            ipq_nxt[fetch_pc[2:0] + 3'd1] = bus_data[15:8];
                            fetch_nxt = fetch_pc + 16'd2;
                        end else begin
                            // Byte fetches only happen at odd addresses: high lane.
                            ipq_nxt[fetch_pc[2:0]] = bus_data[15:8];
                            fetch_nxt = fetch_pc + 16'd1;
                        end
`endif
                    end
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (flush) begin
            head_nxt  = flush_pc;
            fetch_nxt = flush_pc;
            ps_nxt    = flush_ps;
        end else if (consume > ipq_len) begin
            head_nxt = fetch_nxt;
        end else begin
            head_nxt = head_pc + {12'd0, consume};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            head_pc  <= 16'd0;
            fetch_pc <= 16'd0;
            ps       <= 16'd0;
            discard  <= 1'b0;
            bus_req  <= 1'b0;
            bus_addr <= 20'd0;
            bus_word <= 1'b0;
            ipq      <= '0;
        end else if (ce) begin
            state    <= state_nxt;
            head_pc  <= head_nxt;
            fetch_pc <= fetch_nxt;
            ps       <= ps_nxt;
            discard  <= discard_nxt;
            bus_req  <= req_nxt;
            bus_addr <= addr_nxt;
            bus_word <= word_nxt;
            ipq      <= ipq_nxt;
        end
    end
endmodule

// File: tb/tb_nec_prefetch.sv
// tb/tb_nec_prefetch.sv - directed and randomized bench for nec_prefetch against a byte-queue model
module tb_nec_prefetch;
    localparam int MIN_FREE = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ce_1 = 1'b0, ce_2 = 1'b0;
    logic            flush = 1'b0;
    logic [15:0]     flush_ps = '0, flush_pc = '0;
    logic [3:0]      consume = '0;
    logic [3:0]      ipq_len;
    logic [7:0][7:0] ipq;
    logic            bus_req;
    logic [19:0]     bus_addr;
    logic            bus_word;
    logic            bus_ack = 1'b0;
    logic [15:0]     bus_data = '0;

    nec_prefetch #(.QUEUE_SIZE(8), .MIN_FREE(MIN_FREE)) dut (
        .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2),
        .flush(flush), .flush_ps(flush_ps), .flush_pc(flush_pc), .consume(consume),
        .ipq_len(ipq_len), .ipq(ipq), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_word(bus_word), .bus_ack(bus_ack), .bus_data(bus_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: decoder-ordered byte queue plus the single outstanding fetch.
    logic [7:0]  m_q[$];
    logic [15:0] m_head, m_fetch, m_ps;
    logic        m_busy, m_discard, m_word;
    logic [19:0] m_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] mbyte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
    endfunction

    task automatic model_step;
        int  len, free;
        bit  was_busy, issue, iw;
        logic [19:0] ia;
        len = m_q.size(); free = 8 - len;
        was_busy = m_busy; issue = 0; iw = 0; ia = '0;
        if (!was_busy && !flush) begin
            ia = {m_ps, 4'h0} + {4'h0, m_fetch};
`ifdef NEC_PREFETCH_8BIT_EN
            issue = (free >= 1);
`else
            if (m_fetch[0]) issue = (free >= 1);
            else begin iw = 1; issue = (free >= MIN_FREE) && (free >= 2); end
`endif
        end
        if (was_busy && bus_ack) begin
            if (!flush && !m_discard) begin
                m_q.push_back(mbyte(m_addr));
                if (m_word) m_q.push_back(mbyte(m_addr + 20'd1));
                m_fetch = m_fetch + (m_word ? 16'd2 : 16'd1);
            end
            m_busy = 0; m_discard = 0;
        end else if (was_busy && flush) begin
            m_discard = 1;
        end
        if (flush) begin
            m_q.delete(); m_head = flush_pc; m_fetch = flush_pc; m_ps = flush_ps;
        end else if (int'(consume) > len) begin
            m_q.delete(); m_head = m_fetch;
        end else begin
            repeat (int'(consume)) void'(m_q.pop_front());
            m_head = m_head + {12'd0, consume};
        end
        if (issue) begin m_busy = 1; m_addr = ia; m_word = iw; end
    endtask

    task automatic compare;
        logic [63:0] mask, expw;
        int slot;
        mask = '0; expw = '0;
        for (int i = 0; i < m_q.size(); i++) begin
            slot = (int'(m_head[2:0]) + i) % 8;
            mask[slot*8 +: 8] = 8'hFF;
            expw[slot*8 +: 8] = m_q[i];
        end
        check("len", ipq_len, m_q.size());
        check("req", bus_req, m_busy);
        if (m_busy) begin
            check("addr", bus_addr, m_addr);
            check("word", bus_word, m_word);
        end
        check("window", ipq & mask, expw);
    endtask

    task automatic cyc(input logic f, input logic [15:0] fps, input logic [15:0] fpc,
                       input logic [3:0] cons, input logic ack, input logic [1:0] ces);
        flush = f; flush_ps = fps; flush_pc = fpc; consume = cons;
        bus_ack = ack && m_busy;
        ce_1 = ces[0] | bus_ack; ce_2 = ces[1];
        bus_data = 16'($urandom);
        if (bus_ack) begin
`ifdef NEC_PREFETCH_8BIT_EN
            bus_data[7:0] = mbyte(m_addr);
`else
            if (m_word) bus_data = {mbyte(m_addr + 20'd1), mbyte(m_addr)};
            else bus_data[15:8] = mbyte(m_addr);
`endif
        end
        @(posedge clk); #1;
        if (ce_1 | ce_2) model_step();
        flush = 0; bus_ack = 0; consume = 0;
        compare();
    endtask

    task automatic do_reset;
        reset = 1; ce_1 = 0; ce_2 = 0; flush = 0; bus_ack = 0; consume = 0;
        @(posedge clk); #1;
        reset = 0;
        m_q.delete(); m_head = 0; m_fetch = 0; m_ps = 0;
        m_busy = 0; m_discard = 0; m_addr = 0; m_word = 0;
        check("rst_len", ipq_len, 0);
        check("rst_req", bus_req, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_word", bus_word, 0);
        check("rst_ipq", ipq, 0);
    endtask

    initial begin
        int len;
        logic f, ack;
        logic [3:0] cons;
        logic [15:0] fpc;
        do_reset();

        // Fill from an even address
        cyc(1, 16'h1000, 16'h0100, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t1_addr0", bus_addr, 20'h10100);
        check("t1_word0", bus_word, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1, 2'b01);
            check("t1_len", ipq_len, 2 * (k + 1));
            cyc(0, 0, 0, 0, 0, 2'b10);
            if (k < 3) check("t1_addr", bus_addr, 20'h10100 + 20'(2 * (k + 1)));
            else check("t1_full_noreq", bus_req, 0);
        end
        check("t1_ipq0", ipq[0], mbyte(20'h10100));
        check("t1_ipq1", ipq[1], mbyte(20'h10101));

        // Odd start address
        cyc(1, 16'h1000, 16'h0003, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t2_addr0", bus_addr, 20'h10003);
        check("t2_word0", bus_word, 0);
        cyc(0, 0, 0, 0, 1, 2'b01);
        check("t2_ipq3", ipq[3], mbyte(20'h10003));
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t2_addr1", bus_addr, 20'h10004);
        check("t2_word1", bus_word, 1);
        cyc(0, 0, 0, 0, 1, 2'b01);
        check("t2_ipq4", ipq[4], mbyte(20'h10004));
        check("t2_ipq5", ipq[5], mbyte(20'h10005));

        // Fill and consume on one edge, then flush together with ack
        cyc(0, 0, 0, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 1, 2'b01);
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t4_len_before", ipq_len, 5);
        cyc(0, 0, 0, 3, 1, 2'b01);
        check("t4_len_combined", ipq_len, 4);
        cyc(0, 0, 0, 0, 0, 2'b01);
        cyc(1, 16'h1000, 16'h0104, 0, 1, 2'b01);
        check("t4_flush_ack_len", ipq_len, 0);
        check("t4_flush_ack_req", bus_req, 0);

        // Flush while a request is outstanding
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t3_addr0", bus_addr, 20'h10104);
        cyc(1, 16'h1000, 16'h0200, 0, 0, 2'b01);
        check("t3_hold_req", bus_req, 1);
        check("t3_hold_addr", bus_addr, 20'h10104);
        cyc(0, 0, 0, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 0, 2'b11);
        cyc(0, 0, 0, 0, 1, 2'b01);
        check("t3_dropped_len", ipq_len, 0);
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t3_new_addr", bus_addr, 20'h10200);

        // Segment wrap
        cyc(0, 0, 0, 0, 1, 2'b01);
        cyc(1, 16'hF000, 16'hFFFE, 0, 0, 2'b01);
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t5_addr0", bus_addr, 20'hFFFFE);
        cyc(0, 0, 0, 0, 1, 2'b01);
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t5_addr1", bus_addr, 20'hF0000);
        cyc(0, 0, 0, 0, 1, 2'b01);
        check("t5_len", ipq_len, 4);

        // Reset with a request outstanding
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t6_req_before", bus_req, 1);
        do_reset();
        cyc(0, 0, 0, 0, 0, 2'b01);
        check("t6_first_req", bus_req, 1);
        check("t6_first_addr", bus_addr, 20'h00000);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            len = m_q.size();
            f = ($urandom_range(0, 39) == 0);
            if (len < 8 && $urandom_range(0, 29) == 0) cons = 4'($urandom_range(len + 1, 8));
            else cons = 4'($urandom_range(0, len));
            ack = ($urandom_range(0, 2) == 0);
            fpc = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            cyc(f, 16'($urandom), fpc, cons, ack, 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
